// File: rtl/dtcm_ctrl_pkg.sv
// Shared constants, size encodings and FSM state encodings for the DTCM controller.
package dtcm_ctrl_pkg;

  localparam int DTCM_ADDR_W = 16;
  localparam int ITCM_RAM_DW = 32;
  localparam int ITCM_RAM_MW = ITCM_RAM_DW / 8;
  localparam int ITCM_RAM_AW = DTCM_ADDR_W - 2;

  // LSU access size encodings; SIZE_X is the illegal code
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_X = 2'b11;

  typedef enum logic [1:0] {
    DC_IDLE = 2'b00,
    DC_RSP  = 2'b01,
    DC_HOLD = 2'b10
  } dc_state_e;

  // Illegal size, or an address that is not naturally aligned for its size
  function automatic logic access_err(input logic [1:0] size, input logic [1:0] off);
    logic err;
    err = 1'b0;
    case (size)
      SIZE_H:  err = off[0];
      SIZE_W:  err = |off;
      SIZE_X:  err = 1'b1;
      default: err = 1'b0;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load shift/extend and store replicate/byte-mask.
module lsu_align
  import dtcm_ctrl_pkg::*;
#(
  parameter int DW = ITCM_RAM_DW,
  parameter int MW = ITCM_RAM_MW
) (
  input  logic [1:0]    ld_size_i,
  input  logic [1:0]    ld_off_i,
  input  logic          ld_usign_i,
  input  logic [DW-1:0] raw_i,
  output logic [DW-1:0] rdata_o,
  input  logic [1:0]    st_size_i,
  input  logic [1:0]    st_off_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] din_o,
  output logic [MW-1:0] wem_o
);

  logic [DW-1:0] shifted;

  // Load side: bring the addressed lane down to bit 0, then extend
  always_comb begin
    shifted = raw_i >> {ld_off_i, 3'b000};
    rdata_o = shifted;
    case (ld_size_i)
      SIZE_B:  rdata_o = {{(DW-8){~ld_usign_i & shifted[7]}}, shifted[7:0]};
      SIZE_H:  rdata_o = {{(DW-16){~ld_usign_i & shifted[15]}}, shifted[15:0]};
      default: rdata_o = shifted;
    endcase
  end

  // Store side: replicate the right-aligned data into every lane and select lanes by mask
  always_comb begin
    din_o = wdata_i;
    wem_o = '0;
    case (st_size_i)
      SIZE_B: begin
        din_o = {(DW/8){wdata_i[7:0]}};
        wem_o = MW'(1) << st_off_i;
      end
      SIZE_H: begin
        din_o = {(DW/16){wdata_i[15:0]}};
        wem_o = MW'(3) << {st_off_i[1], 1'b0};
      end
      SIZE_W: begin
        din_o = wdata_i;
        wem_o = '1;
      end
      default: begin
        din_o = wdata_i;
        wem_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/dtcm_ctrl.sv
// DTCM SRAM initiator: LSU command channel in, SRAM port out, one response per command.
module dtcm_ctrl
  import dtcm_ctrl_pkg::*;
#(
  parameter int AW  = DTCM_ADDR_W,
  parameter int DW  = ITCM_RAM_DW,
  parameter int MW  = ITCM_RAM_MW,
  parameter int RAW = ITCM_RAM_AW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic           cmd_read,
  input  logic [AW-1:0]  cmd_addr,
  input  logic [1:0]     cmd_size,
  input  logic           cmd_usign,
  input  logic [DW-1:0]  cmd_wdata,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [DW-1:0]  rsp_rdata,
  output logic           rsp_err,
  output logic           dtcm_ram_we,
  output logic [RAW-1:0] dtcm_ram_addr,
  output logic [DW-1:0]  dtcm_ram_din,
  output logic [MW-1:0]  dtcm_ram_wem,
  input  logic [DW-1:0]  dtcm_ram_dout
);

  dc_state_e      state_q;
  logic           rsp_valid_q;
  logic [DW-1:0]  hold_q;
  logic [RAW-1:0] addr_q;
  logic [RAW-1:0] addr_d;

  logic           ctx_read_q;
  logic           ctx_err_q;
  logic [1:0]     ctx_size_q;
  logic           ctx_usign_q;
  logic [1:0]     ctx_off_q;

  logic           acc;
  logic           cmd_err;
  logic           ram_go;
  logic           st_go;
  logic [DW-1:0]  ld_data;
  logic [DW-1:0]  rsp_live;
  logic [DW-1:0]  st_din;
  logic [MW-1:0]  st_wem;

  // A new command may enter whenever the current response leaves this cycle (or none is pending)
  always_comb begin
    cmd_ready = 1'b0;
    if (!rst) begin
      case (state_q)
        DC_IDLE: cmd_ready = 1'b1;
        DC_RSP:  cmd_ready = rsp_ready;
        DC_HOLD: cmd_ready = rsp_ready;
        default: cmd_ready = 1'b0;
      endcase
    end
  end

  assign acc     = cmd_valid & cmd_ready;
  assign cmd_err = access_err(cmd_size, cmd_addr[1:0]);
  assign ram_go  = acc & ~cmd_err;
  assign st_go   = ram_go & ~cmd_read;

  lsu_align #(
    .DW (DW),
    .MW (MW)
  ) u_align (
    .ld_size_i  (ctx_size_q),
    .ld_off_i   (ctx_off_q),
    .ld_usign_i (ctx_usign_q),
    .raw_i      (dtcm_ram_dout),
    .rdata_o    (ld_data),
    .st_size_i  (cmd_size),
    .st_off_i   (cmd_addr[1:0]),
    .wdata_i    (cmd_wdata),
    .din_o      (st_din),
    .wem_o      (st_wem)
  );

  // SRAM port is driven straight from the accepted command; the address sticks when idle
  always_comb begin
    addr_d = ram_go ? cmd_addr[AW-1:2] : addr_q;
  end

  assign dtcm_ram_we   = st_go;
  assign dtcm_ram_wem  = st_go ? st_wem : '0;
  assign dtcm_ram_din  = st_go ? st_din : '0;
  assign dtcm_ram_addr = addr_d;

  // Stores and erroring commands answer with zero data
  assign rsp_live = (ctx_read_q && !ctx_err_q) ? ld_data : '0;

  // Response mux: live SRAM path in RSP, captured copy while back-pressured
  always_comb begin
    rsp_rdata = '0;
    case (state_q)
      DC_RSP:  rsp_rdata = rsp_live;
      DC_HOLD: rsp_rdata = hold_q;
      default: rsp_rdata = '0;
    endcase
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_valid_q & ctx_err_q;

  // Response FSM with registered rsp_valid, hold capture and sticky SRAM address
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= DC_IDLE;
      rsp_valid_q <= 1'b0;
      hold_q      <= '0;
      addr_q      <= '0;
      ctx_err_q   <= 1'b0;
    end else begin
      addr_q <= addr_d;
      if (acc) begin
        ctx_err_q <= cmd_err;
      end
      case (state_q)
        DC_IDLE: begin
          if (acc) begin
            state_q     <= DC_RSP;
            rsp_valid_q <= 1'b1;
          end
        end
        DC_RSP: begin
          if (rsp_ready) begin
            if (!acc) begin
              state_q     <= DC_IDLE;
              rsp_valid_q <= 1'b0;
            end
          end else begin
            hold_q  <= rsp_live;
            state_q <= DC_HOLD;
          end
        end
        DC_HOLD: begin
          if (rsp_ready) begin
            if (acc) begin
              state_q <= DC_RSP;
            end else begin
              state_q     <= DC_IDLE;
              rsp_valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q     <= DC_IDLE;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Per-response context captured at accept
  always_ff @(posedge clk) begin
    if (acc) begin
      ctx_read_q  <= cmd_read;
      ctx_size_q  <= cmd_size;
      ctx_usign_q <= cmd_usign;
      ctx_off_q   <= cmd_addr[1:0];
    end
  end

endmodule

// File: tb/tb_dtcm_ctrl.sv
// Bench for dtcm_ctrl: directed vector table plus hand-written back-pressure and reset sequences.
module tb_dtcm_ctrl;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_read;
  logic [15:0] cmd_addr;
  logic [1:0]  cmd_size;
  logic        cmd_usign;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        dtcm_ram_we;
  logic [13:0] dtcm_ram_addr;
  logic [31:0] dtcm_ram_din;
  logic [3:0]  dtcm_ram_wem;
  logic [31:0] dtcm_ram_dout;

  int checks;
  int failures;

  logic [31:0] mem [0:16383];

  dtcm_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_read      (cmd_read),
    .cmd_addr      (cmd_addr),
    .cmd_size      (cmd_size),
    .cmd_usign     (cmd_usign),
    .cmd_wdata     (cmd_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err),
    .dtcm_ram_we   (dtcm_ram_we),
    .dtcm_ram_addr (dtcm_ram_addr),
    .dtcm_ram_din  (dtcm_ram_din),
    .dtcm_ram_wem  (dtcm_ram_wem),
    .dtcm_ram_dout (dtcm_ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port SRAM model: masked write, otherwise registered read of the current address
  always @(posedge clk) begin
    if (dtcm_ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (dtcm_ram_wem[b]) mem[dtcm_ram_addr][8*b +: 8] <= dtcm_ram_din[8*b +: 8];
      end
    end else begin
      dtcm_ram_dout <= mem[dtcm_ram_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic [15:0] a, input logic [1:0] sz,
                       input logic us, input logic [31:0] wd);
    cmd_valid = 1'b1;
    cmd_read  = rd;
    cmd_addr  = a;
    cmd_size  = sz;
    cmd_usign = us;
    cmd_wdata = wd;
  endtask

  typedef struct {
    logic        rd;
    logic [15:0] addr;
    logic [1:0]  size;
    logic        usign;
    logic [31:0] wdata;
    logic        e_we;
    logic [3:0]  e_wem;
    logic [31:0] e_din;
    logic        e_err;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t        vt [19];
  logic [13:0] exp_addr;
  logic [31:0] held;

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
    checks = 0;
    failures = 0;
    rst = 1'b1;
    rsp_ready = 1'b1;
    drive(1'b0, 16'h0010, 2'b10, 1'b0, 32'hCAFEF00D);
    dtcm_ram_dout = 32'h0;

    //            rd    addr      sz     us    wdata          we    wem      din            err   rdata
    vt[0]  = '{1'b0, 16'h0010, 2'b10, 1'b0, 32'hDEADBEEF, 1'b1, 4'b1111, 32'hDEADBEEF, 1'b0, 32'h0};
    vt[1]  = '{1'b1, 16'h0010, 2'b10, 1'b0, 32'h0,        1'b0, 4'b0000, 32'h0,        1'b0, 32'hDEADBEEF};
    vt[2]  = '{1'b0, 16'h0013, 2'b00, 1'b0, 32'h00000080, 1'b1, 4'b1000, 32'h80808080, 1'b0, 32'h0};
    vt[3]  = '{1'b1, 16'h0013, 2'b00, 1'b0, 32'h0,        1'b0, 4'b0000, 32'h0,        1'b0, 32'hFFFFFF80};
    vt[4]  = '{1'b1, 16'h0013, 2'b00, 1'b1, 32'h0,        1'b0, 4'b0000, 32'h0,        1'b0, 32'h00000080};
    vt[5]  = '{1'b1, 16'h0011, 2'b01, 1'b0, 32'h0,        1'b0, 4'b0000, 32'h0,        1'b1, 32'h0};
    vt[6]  = '{1'b0, 16'h0012, 2'b10, 1'b0, 32'h12345678, 1'b0, 4'b0000, 32'h0,        1'b1, 32'h0};
    vt[7]  = '{1'b1, 16'h0010, 2'b10, 1'b0, 32'h0,        1'b0, 4'b0000, 32'h0,        1'b0, 32'h80ADBEEF};
    vt[8]  = '{1'b0, 16'h0016, 2'b01, 1'b0, 32'hFFFFA5C3, 1'b1, 4'b1100, 32'hA5C3A5C3, 1'b0, 32'h0};
    vt[9]  = '{1'b1, 16'h0016, 2'b01, 1'b0, 32'h0,        1'b0, 4'b0000, 32'h0,        1'b0, 32'hFFFFA5C3};
    vt[10] = '{1'b1, 16'h0014, 2'b01, 1'b1, 32'h0,        1'b0, 4'b0000, 32'h0,        1'b0, 32'h0};
    vt[11] = '{1'b1, 16'h0012, 2'b00, 1'b0, 32'h0,        1'b0, 4'b0000, 32'h0,        1'b0, 32'hFFFFFFAD};
    vt[12] = '{1'b1, 16'h0010, 2'b11, 1'b0, 32'h0,        1'b0, 4'b0000, 32'h0,        1'b1, 32'h0};
    vt[13] = '{1'b0, 16'h0011, 2'b00, 1'b0, 32'h0000007F, 1'b1, 4'b0010, 32'h7F7F7F7F, 1'b0, 32'h0};
    vt[14] = '{1'b1, 16'h0011, 2'b00, 1'b0, 32'h0,        1'b0, 4'b0000, 32'h0,        1'b0, 32'h0000007F};
    vt[15] = '{1'b1, 16'h0010, 2'b10, 1'b0, 32'h0,        1'b0, 4'b0000, 32'h0,        1'b0, 32'h80AD7FEF};
    vt[16] = '{1'b1, 16'h0016, 2'b01, 1'b1, 32'h0,        1'b0, 4'b0000, 32'h0,        1'b0, 32'h0000A5C3};
    vt[17] = '{1'b0, 16'h0010, 2'b01, 1'b0, 32'h00001234, 1'b1, 4'b0011, 32'h12341234, 1'b0, 32'h0};
    vt[18] = '{1'b1, 16'h0010, 2'b10, 1'b0, 32'h0,        1'b0, 4'b0000, 32'h0,        1'b0, 32'h80AD1234};

    // Reset: outputs quiet and command side blocked even with a store presented
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'h0);
    chk("rst_we", 32'(dtcm_ram_we), 32'h0);
    chk("rst_wem", 32'(dtcm_ram_wem), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_addr", 32'(dtcm_ram_addr), 32'h0);
    cmd_valid = 1'b0;
    rst = 1'b0;
    exp_addr = 14'h0;

    // Table: one command, check SRAM side, then check the response one cycle later
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      drive(vt[i].rd, vt[i].addr, vt[i].size, vt[i].usign, vt[i].wdata);
      if (!vt[i].e_err) exp_addr = vt[i].addr[15:2];
      #1;
      chk($sformatf("v%0d_cmd_ready", i), 32'(cmd_ready), 32'h1);
      chk($sformatf("v%0d_we", i), 32'(dtcm_ram_we), 32'(vt[i].e_we));
      chk($sformatf("v%0d_wem", i), 32'(dtcm_ram_wem), 32'(vt[i].e_wem));
      chk($sformatf("v%0d_addr", i), 32'(dtcm_ram_addr), 32'(exp_addr));
      if (vt[i].e_we) chk($sformatf("v%0d_din", i), dtcm_ram_din, vt[i].e_din);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'h1);
      chk($sformatf("v%0d_rsp_err", i), 32'(rsp_err), 32'(vt[i].e_err));
      chk($sformatf("v%0d_rsp_rdata", i), rsp_rdata, vt[i].e_rdata);
    end
    @(negedge clk);
    chk("idle_rsp_valid", 32'(rsp_valid), 32'h0);

    // Back-to-back load/store/load on one word: old data, then new data
    drive(1'b1, 16'h0020, 2'b10, 1'b0, 32'h0);
    @(negedge clk);
    chk("war_ld_valid", 32'(rsp_valid), 32'h1);
    chk("war_ld_rdata", rsp_rdata, 32'h0);
    drive(1'b0, 16'h0020, 2'b10, 1'b0, 32'h11111111);
    #1;
    chk("war_st_ready", 32'(cmd_ready), 32'h1);
    chk("war_st_we", 32'(dtcm_ram_we), 32'h1);
    @(negedge clk);
    chk("war_st_valid", 32'(rsp_valid), 32'h1);
    chk("war_st_rdata", rsp_rdata, 32'h0);
    drive(1'b1, 16'h0020, 2'b10, 1'b0, 32'h0);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("raw_ld_valid", 32'(rsp_valid), 32'h1);
    chk("raw_ld_rdata", rsp_rdata, 32'h11111111);
    @(negedge clk);

    // Back-pressure: second load blocked for 3 cycles, first response must stay frozen
    drive(1'b1, 16'h0010, 2'b10, 1'b0, 32'h0);
    @(negedge clk);
    rsp_ready = 1'b0;
    drive(1'b1, 16'h0014, 2'b10, 1'b0, 32'h0);
    #1;
    chk("bp_valid", 32'(rsp_valid), 32'h1);
    chk("bp_rdata0", rsp_rdata, 32'h80AD1234);
    held = rsp_rdata;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("bp_ready_low%0d", c), 32'(cmd_ready), 32'h0);
      mem[4] = 32'h0BAD0000 + 32'(c);
      @(negedge clk);
      #1;
      chk($sformatf("bp_stable%0d", c), rsp_rdata, held);
      chk($sformatf("bp_valid%0d", c), 32'(rsp_valid), 32'h1);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(cmd_ready), 32'h1);
    chk("bp_release_rdata", rsp_rdata, 32'h80AD1234);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("bp_second_valid", 32'(rsp_valid), 32'h1);
    chk("bp_second_rdata", rsp_rdata, 32'hA5C30000);
    @(negedge clk);
    chk("bp_drain_valid", 32'(rsp_valid), 32'h0);

    // Reset while holding a response: it is dropped, then a fresh load works normally
    drive(1'b1, 16'h0014, 2'b10, 1'b0, 32'h0);
    rsp_ready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("hrst_pre_valid", 32'(rsp_valid), 32'h1);
    rst = 1'b1;
    #1;
    chk("hrst_cmd_ready", 32'(cmd_ready), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    rsp_ready = 1'b1;
    chk("hrst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("hrst_rsp_rdata", rsp_rdata, 32'h0);
    chk("hrst_addr", 32'(dtcm_ram_addr), 32'h0);
    drive(1'b1, 16'h0016, 2'b01, 1'b0, 32'h0);
    #1;
    chk("hrst_idle_ready", 32'(cmd_ready), 32'h1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("hrst_post_valid", 32'(rsp_valid), 32'h1);
    chk("hrst_post_rdata", rsp_rdata, 32'hFFFFA5C3);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
